// File: rtl/gpu_clk_pkg.sv
// gpu_clk_pkg: shared state encoding and default parameters for the PLL reset sequencer
package gpu_clk_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } seq_state_t;
  localparam int LOCK_LOST_W            = 8;
  localparam int DEF_NUM_DOMAINS        = 3;
  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_FILTER_CYCLES = 256;
  localparam int DEF_STAGE_GAP_CYCLES   = 16;
  localparam int DEF_LOSS_HOLD_CYCLES   = 64;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for one asynchronous bit, clears to 0 on reset
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  // shift the raw bit into the bottom of the chain
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  // synchroniser chain registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: filters PLL lock and releases per-domain resets in order
module pll_reset_sequencer
  import gpu_clk_pkg::*;
#(
  parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER_CYCLES = DEF_LOCK_FILTER_CYCLES,
  parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
  parameter int LOSS_HOLD_CYCLES   = DEF_LOSS_HOLD_CYCLES
) (
  input  logic                   clk_core,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   all_ready,
  output logic [LOCK_LOST_W-1:0] lock_lost_count,
  output logic [2:0]             seq_state
);
  localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP_CYCLES + 1);
  localparam int HW = $clog2(LOSS_HOLD_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOSS_HOLD_CYCLES - 1);
  seq_state_t             state_q, state_d;
  logic [FW-1:0]          filt_q, filt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_DOMAINS-1:0] rel_q, rel_d, rel_next;
  logic                   ready_q, ready_d;
  logic [LOCK_LOST_W-1:0] lost_q, lost_d;
  logic                   locked_s;
  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_core),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );
  assign rel_next = rel_q | (rel_q << 1);
  // sequencing FSM: lock filter, staged release, fault hold
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    ready_d = ready_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        rel_d   = '0;
        ready_d = 1'b0;
        if (locked_s) begin
          state_d = FILTER;
          filt_d  = '0;
        end
      end
      FILTER: begin
        if (sw_reset_req) begin
          state_d = HOLD;
          hold_d  = '0;
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (filt_q == FILT_LAST) begin
          state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
          rel_d   = NUM_DOMAINS'(1);
          ready_d = (NUM_DOMAINS == 1);
          gap_d   = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!locked_s || sw_reset_req) begin
          state_d = HOLD;
          hold_d  = '0;
          rel_d   = '0;
          ready_d = 1'b0;
          if (!locked_s && lost_q != '1) lost_d = lost_q + 1'b1;
        end else if (state_q == RELEASE) begin
          gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
          if (gap_q == GAP_LAST) begin
            rel_d = rel_next;
            if (rel_next[NUM_DOMAINS-1]) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        rel_d   = '0;
        ready_d = 1'b0;
        if (hold_q == HOLD_LAST) state_d = WAIT_LOCK;
        else hold_d = hold_q + 1'b1;
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
        rel_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end
  // state, counters and registered outputs
  always_ff @(posedge clk_core or negedge rst_n)
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  assign rst_out_n       = rel_q;
  assign all_ready       = ready_q;
  assign lock_lost_count = lost_q;
  assign seq_state       = state_q;
endmodule
